// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one external combinational multiplier between NREQ
// requesters. A round-robin arbiter picks one request in IDLE and registers
// its operands into the multiplier. The product is captured one cycle later
// and held on a valid/ready response channel, tagged with the requester ID.
// Only one transaction is in flight at a time.
module mult_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_p,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IDW-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] winner;
    logic           found;
    int             scan_sum;
    logic [IDW-1:0] scan_idx;

    // Round-robin search: first valid requester after the last winner, wrapping
    // around; the modulo is a conditional subtract so NREQ need not be 2^n.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = 0;
        scan_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= NREQ) begin
                scan_sum = scan_sum - NREQ;
            end
            scan_idx = IDW'(scan_sum);
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // One-hot grant, only while IDLE; forced low while reset is held.
    always_comb begin
        req_ready = '0;
        if (!reset && (state == IDLE) && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state logic: IDLE -> CALC on a winner, CALC lasts one cycle,
    // HOLD waits for the response handshake.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (found) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                next_state = HOLD;
            end
            HOLD: begin
                if (rsp_valid && rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Datapath: operands captured on accept and kept afterwards, product
    // captured at the end of CALC, response valid dropped on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= IDW'(NREQ - 1);
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        mul_a  <= req_a[int'(winner)*WIDTH +: WIDTH];
                        mul_b  <= req_b[int'(winner)*WIDTH +: WIDTH];
                        rsp_id <= winner;
                        rr_ptr <= winner;
                    end
                end
                CALC: begin
                    rsp_data  <= mul_p;
                    rsp_valid <= 1'b1;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/mult_share_arb.md
Name: mult_share_arb

Overview:
- Time-shares one combinational 8x8 unsigned multiplier (a * b -> 16-bit product) between NREQ requesters.
- Arbitrates requests round-robin and registers the selected operands into the multiplier.
- Captures the product and returns it with the requester ID over a valid/ready response channel.
- Sits between the lab's requester blocks and the single multiplier instance; one transaction in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; product width is 2*WIDTH.
- IDW, 2, requester ID width; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same packing as req_a.
- mul_a  out  WIDTH  operand A to the shared multiplier.
- mul_b  out  WIDTH  operand B to the shared multiplier.
- mul_p  in  2*WIDTH  product from the shared multiplier (combinational).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_data  out  2*WIDTH  product.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; rr_ptr = NREQ-1, so requester 0 has first priority.
  - mul_a, mul_b, rsp_data, rsp_id = 0; rsp_valid = 0; busy = 0; req_ready = 0.
  - Reset mid-transaction aborts it. No response is produced and the accepted request is lost.
- States: IDLE -> CALC -> HOLD -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i] = 1, searching (rr_ptr+1) mod NREQ upward with wrap-around.
  - req_ready[winner] is driven combinationally high in IDLE only; all other bits are 0.
  - On the clock edge with a winner: mul_a/mul_b <= winner's operands; rsp_id <= winner; rr_ptr <= winner; go to CALC.
  - No req_valid: stay in IDLE; rr_ptr unchanged.
- CALC (exactly one cycle):
  - mul_a/mul_b are held stable; req_ready = 0.
  - On the edge: rsp_data <= mul_p; rsp_valid <= 1; go to HOLD.
- HOLD:
  - rsp_valid = 1; rsp_data and rsp_id held stable; req_ready = 0.
  - When rsp_valid & rsp_ready at the edge: rsp_valid <= 0; go to IDLE.
  - Otherwise stay in HOLD indefinitely (backpressure).
- Latency: rsp_valid rises 2 cycles after the accept edge. Minimum issue interval is 3 cycles (accept, CALC, HOLD with rsp_ready = 1).
- mul_a/mul_b keep their last operands after the transaction; they change only on the next accept.
- Arithmetic: unsigned. rsp_data is the full 2*WIDTH product with no truncation; 255*255 = 16'hFE01.
- A requester may drop req_valid before it is granted with no effect. Operands are sampled only on the accept edge, so later changes do not affect the result.
- Requests arriving during CALC/HOLD wait. Arbitration uses the req_valid values present in the IDLE cycle.
- busy = (state != IDLE).

Test Plan:
- Reset, then only req_valid[2] with a = 8'd12, b = 8'd13 -> req_ready = 4'b0100 in that cycle; 2 cycles later rsp_valid = 1, rsp_id = 2, rsp_data = 16'd156; rsp_ready = 1 returns to IDLE.
- All four requests held valid continuously, rsp_ready = 1 -> grant order 0, 1, 2, 3, 0; one response every 3 cycles; each rsp_id matches its grant.
- a = 8'hFF, b = 8'hFF -> rsp_data = 16'hFE01; a = 0, b = 8'hAB -> rsp_data = 0.
- rsp_ready = 0 for 5 cycles after rsp_valid, with req_valid[1] pending -> rsp_valid, rsp_data and rsp_id held stable; req_ready stays 0; req 1 is granted in the IDLE cycle following the handshake.
- Assert reset during CALC -> all outputs 0 immediately; no response; after release, req 0 wins a simultaneous 0/3 request.
- Change req_a[1] in the cycle after accept (a = 3, b = 4, then a -> 9) -> rsp_data = 16'd12.
